imem_loader: RTL and testbench

Sequencer and port arbiter for the writable 128 x 32 instruction memory of the pipelined ARM core. After reset it erases the memory to a self-loop halt word. On request it streams a program from a host valid/ready port into memory and pads the unused tail with the halt word. It holds the core off the memory until the image is complete, then hands the read port to instruction fetch.

---
 rtl/imem_loader.sv | 149 ++++++++++++++
 tb/tb_imem_loader.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Sequencer/arbiter for the 128x32 instruction memory: erase to HALT after reset,
// stream a host image in, pad the tail with HALT, then hand the port to fetch.
module imem_loader #(
    parameter int             N     = 32,
    parameter int             AW    = 7,
    parameter int             DEPTH = 128,
    parameter logic [N-1:0]   HALT  = 32'hb400001f,
    parameter logic [N-1:0]   NOP   = 32'h8b1f03ff
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_load,
    input  logic          host_valid,
    input  logic [N-1:0]  host_data,
    input  logic          host_last,
    output logic          host_ready,
    input  logic [AW-1:0] fetch_addr,
    output logic [N-1:0]  fetch_q,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [N-1:0]  mem_wdata,
    input  logic [N-1:0]  mem_q,
    output logic          cpu_hold,
    output logic          load_done,
    output logic          err,
    output logic [AW:0]   word_count
);

    localparam int PW = AW + 1;
    localparam logic [AW:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [AW:0] PTR_ONE  = PW'(1);

    typedef enum logic [2:0] {
        CLEAR = 3'd0,
        RUN   = 3'd1,
        LOAD  = 3'd2,
        FILL  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          we_raw;
    logic [N-1:0]  wdata_raw;
    logic [AW-1:0] addr_raw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= CLEAR;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        err_d     = err_q;
        done_d    = 1'b0;
        we_raw    = 1'b0;
        wdata_raw = HALT;
        addr_raw  = wr_ptr_q[AW-1:0];
        unique case (state_q)
            CLEAR: begin
                we_raw   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (wr_ptr_q == PTR_LAST) begin
                    state_d  = RUN;
                    wr_ptr_d = '0;
                end
            end
            RUN: begin
                addr_raw = fetch_addr;
                if (start_load) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    err_d    = 1'b0;
                end
            end
            LOAD: begin
                wdata_raw = host_data;
                // A restart wins over any word offered in the same cycle.
                if (start_load) begin
                    wr_ptr_d = '0;
                    count_d  = '0;
                end else if (wr_ptr_q[AW]) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else if (host_valid) begin
                    we_raw   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    count_d  = count_q + PTR_ONE;
                    if (host_last) begin
                        if (wr_ptr_q == PTR_LAST) begin
                            state_d  = RUN;
                            done_d   = 1'b1;
                            wr_ptr_d = '0;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
            end
            FILL: begin
                we_raw   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (wr_ptr_q == PTR_LAST) begin
                    state_d  = RUN;
                    done_d   = 1'b1;
                    wr_ptr_d = '0;
                end
            end
            ERROR: begin
                if (start_load) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    err_d    = 1'b0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Gate the write strobe with reset so nothing lands in memory once reset asserts.
    assign mem_we     = we_raw & reset;
    assign mem_addr   = addr_raw;
    assign mem_wdata  = wdata_raw;
    assign host_ready = (state_q == LOAD) && !wr_ptr_q[AW];
    assign cpu_hold   = (state_q != RUN);
    assign fetch_q    = (state_q == RUN) ? mem_q : NOP;
    assign load_done  = done_q;
    assign err        = err_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a behavioural 128x32 memory attached.
module tb_imem_loader;

    localparam logic [31:0] HALT = 32'hb400001f;
    localparam logic [31:0] NOP  = 32'h8b1f03ff;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_load;
    logic        host_valid;
    logic [31:0] host_data;
    logic        host_last;
    logic        host_ready;
    logic [6:0]  fetch_addr;
    logic [31:0] fetch_q;
    logic [6:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_q;
    logic        cpu_hold;
    logic        load_done;
    logic        err;
    logic [7:0]  word_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [128];

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start_load (start_load),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_last  (host_last),
        .host_ready (host_ready),
        .fetch_addr (fetch_addr),
        .fetch_q    (fetch_q),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_q      (mem_q),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_q = mem[mem_addr];

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic sl, input logic hv, input logic hl, input logic [31:0] hd);
        start_load = sl;
        host_valid = hv;
        host_last  = hl;
        host_data  = hd;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        fetch_addr = '0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        checks++;
        if ({cpu_hold, host_ready, load_done, err, word_count, mem_we, fetch_q} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, NOP}) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected %h",
                     {cpu_hold, host_ready, load_done, err, word_count, mem_we, fetch_q}, {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, NOP});
        end
    endtask

    task automatic run_clear(input string tag);
        for (int i = 0; i < 128; i++) begin
            checks++;
            if ({mem_we, mem_addr, mem_wdata, cpu_hold, fetch_q} !== {1'b1, 7'(i), HALT, 1'b1, NOP}) begin
                errors++;
                $display("FAIL %s_write[%0d]: got %h, expected %h", tag, i,
                         {mem_we, mem_addr, mem_wdata, cpu_hold, fetch_q}, {1'b1, 7'(i), HALT, 1'b1, NOP});
            end
            tick();
        end
        checks++;
        if ({cpu_hold, mem_we, load_done} !== 3'b000) begin
            errors++;
            $display("FAIL %s_run_entry: got hold/we/done=%b, expected 000", tag, {cpu_hold, mem_we, load_done});
        end
        $display("txn %s: 128 erase writes done", tag);
    endtask

    task automatic test_clear;
        logic [6:0] fa [3];
        fa = '{7'd0, 7'd5, 7'd127};
        @(negedge clk);
        reset = 1'b1;
        #1;
        run_clear("clear");
        for (int k = 0; k < 3; k++) begin
            fetch_addr = fa[k];
            #1;
            checks++;
            if ({mem_addr, fetch_q} !== {fa[k], HALT}) begin
                errors++;
                $display("FAIL clear_fetch[%0d]: got %h, expected %h", fa[k], {mem_addr, fetch_q}, {fa[k], HALT});
            end
        end
    endtask

    task automatic test_load16;
        logic [31:0] w;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if ({cpu_hold, host_ready} !== 2'b00) begin
            errors++;
            $display("FAIL load16_run_before: got hold/ready=%b, expected 00", {cpu_hold, host_ready});
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if ({cpu_hold, host_ready, word_count, fetch_q} !== {1'b1, 1'b1, 8'd0, NOP}) begin
            errors++;
            $display("FAIL load16_enter: got %h, expected %h", {cpu_hold, host_ready, word_count, fetch_q}, {1'b1, 1'b1, 8'd0, NOP});
        end
        for (int i = 0; i < 16; i++) begin
            w = (i == 15) ? HALT : 32'hf8000001 + 32'(i);
            drive(1'b0, 1'b1, (i == 15), w);
            checks++;
            if ({mem_we, mem_addr, mem_wdata, host_ready, fetch_q} !== {1'b1, 7'(i), w, 1'b1, NOP}) begin
                errors++;
                $display("FAIL load16_word[%0d]: got %h, expected %h", i,
                         {mem_we, mem_addr, mem_wdata, host_ready, fetch_q}, {1'b1, 7'(i), w, 1'b1, NOP});
            end
            $display("txn load16 addr=%0d data=%h", i, w);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        for (int j = 16; j < 128; j++) begin
            checks++;
            if ({mem_we, mem_addr, mem_wdata, host_ready, load_done, cpu_hold, fetch_q} !== {1'b1, 7'(j), HALT, 1'b0, 1'b0, 1'b1, NOP}) begin
                errors++;
                $display("FAIL load16_fill[%0d]: got %h, expected %h", j,
                         {mem_we, mem_addr, mem_wdata, host_ready, load_done, cpu_hold, fetch_q},
                         {1'b1, 7'(j), HALT, 1'b0, 1'b0, 1'b1, NOP});
            end
            tick();
        end
        checks++;
        if ({cpu_hold, load_done, word_count, mem_we} !== {1'b0, 1'b1, 8'd16, 1'b0}) begin
            errors++;
            $display("FAIL load16_done: got %h, expected %h", {cpu_hold, load_done, word_count, mem_we}, {1'b0, 1'b1, 8'd16, 1'b0});
        end
        tick();
        checks++;
        if (load_done !== 1'b0) begin
            errors++;
            $display("FAIL load16_done_pulse: got %b, expected 0", load_done);
        end
        fetch_addr = 7'd5;
        #1;
        checks++;
        if (fetch_q !== 32'hf8000006) begin
            errors++;
            $display("FAIL load16_fetch5: got %h, expected f8000006", fetch_q);
        end
        fetch_addr = 7'd100;
        #1;
        checks++;
        if (fetch_q !== HALT) begin
            errors++;
            $display("FAIL load16_fetch100: got %h, expected %h", fetch_q, HALT);
        end
    endtask

    task automatic test_backpressure;
        logic [4:0]  v;
        logic [31:0] d;
        int a;
        int fills;
        int n;
        v = 5'b11001;
        a = 0;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        for (int k = 0; k < 5; k++) begin
            d = 32'hc0de0000 + 32'(k);
            drive(1'b0, v[k], 1'b0, d);
            checks++;
            if (v[k]) begin
                if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 7'(a), d}) begin
                    errors++;
                    $display("FAIL bp_write[%0d]: got %h, expected %h", k, {mem_we, mem_addr, mem_wdata}, {1'b1, 7'(a), d});
                end
                $display("txn bp addr=%0d data=%h", a, d);
                a++;
            end else if ({mem_we, host_ready} !== 2'b01) begin
                errors++;
                $display("FAIL bp_idle[%0d]: got we/ready=%b, expected 01", k, {mem_we, host_ready});
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (word_count !== 8'd3) begin
            errors++;
            $display("FAIL bp_count: got %0d, expected 3", word_count);
        end
        drive(1'b0, 1'b1, 1'b1, 32'hc0de00ff);
        checks++;
        if ({mem_we, mem_addr} !== {1'b1, 7'd3}) begin
            errors++;
            $display("FAIL bp_last: got %h, expected %h", {mem_we, mem_addr}, {1'b1, 7'd3});
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        fills = 0;
        n = 0;
        while (cpu_hold && n < 300) begin
            if (mem_we) fills++;
            tick();
            n++;
        end
        checks++;
        if ({cpu_hold, word_count} !== {1'b0, 8'd4} || fills != 124) begin
            errors++;
            $display("FAIL bp_fill: got hold=%b count=%0d fills=%0d, expected hold=0 count=4 fills=124", cpu_hold, word_count, fills);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 128; i++) begin
            d = 32'ha0000000 | 32'(i);
            drive(1'b0, 1'b1, 1'b0, d);
            checks++;
            if ({mem_we, mem_addr, mem_wdata, host_ready} !== {1'b1, 7'(i), d, 1'b1}) begin
                errors++;
                $display("FAIL ovf_word[%0d]: got %h, expected %h", i, {mem_we, mem_addr, mem_wdata, host_ready}, {1'b1, 7'(i), d, 1'b1});
            end
            $display("txn ovf addr=%0d data=%h", i, d);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 32'ha0000080);
        checks++;
        if ({host_ready, mem_we, word_count, err, cpu_hold} !== {1'b0, 1'b0, 8'd128, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_full: got %h, expected %h", {host_ready, mem_we, word_count, err, cpu_hold}, {1'b0, 1'b0, 8'd128, 1'b0, 1'b1});
        end
        for (int r = 0; r < 2; r++) begin
            tick();
            checks++;
            if ({err, cpu_hold, host_ready, mem_we} !== 4'b1100) begin
                errors++;
                $display("FAIL ovf_error[%0d]: got err/hold/ready/we=%b, expected 1100", r, {err, cpu_hold, host_ready, mem_we});
            end
        end
        drive(1'b1, 1'b1, 1'b0, 32'hdead0000);
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL ovf_exit_we: got %b, expected 0", mem_we);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if ({err, word_count, host_ready, cpu_hold} !== {1'b0, 8'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ovf_reload: got %h, expected %h", {err, word_count, host_ready, cpu_hold}, {1'b0, 8'd0, 1'b1, 1'b1});
        end
    endtask

    task automatic test_restart;
        logic [31:0] d;
        for (int i = 0; i < 5; i++) begin
            d = 32'h55000000 + 32'(i);
            drive(1'b0, 1'b1, 1'b0, d);
            checks++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 7'(i), d}) begin
                errors++;
                $display("FAIL rs_word[%0d]: got %h, expected %h", i, {mem_we, mem_addr, mem_wdata}, {1'b1, 7'(i), d});
            end
            $display("txn restart addr=%0d data=%h", i, d);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 32'h66666666);
        checks++;
        if ({mem_we, word_count} !== {1'b0, 8'd5}) begin
            errors++;
            $display("FAIL rs_nowrite: got %h, expected %h", {mem_we, word_count}, {1'b0, 8'd5});
        end
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h77777777);
        checks++;
        if ({word_count, mem_we, mem_addr, mem_wdata} !== {8'd0, 1'b1, 7'd0, 32'h77777777}) begin
            errors++;
            $display("FAIL rs_first: got %h, expected %h", {word_count, mem_we, mem_addr, mem_wdata}, {8'd0, 1'b1, 7'd0, 32'h77777777});
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if ({word_count, mem_we, mem_addr, host_ready} !== {8'd1, 1'b1, 7'd1, 1'b0}) begin
            errors++;
            $display("FAIL rs_fill: got %h, expected %h", {word_count, mem_we, mem_addr, host_ready}, {8'd1, 1'b1, 7'd1, 1'b0});
        end
    endtask

    task automatic test_reset_mid_fill;
        for (int a = 1; a < 40; a++) begin
            checks++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 7'(a), HALT}) begin
                errors++;
                $display("FAIL mf_fill[%0d]: got %h, expected %h", a, {mem_we, mem_addr, mem_wdata}, {1'b1, 7'(a), HALT});
            end
            tick();
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_we, cpu_hold, host_ready, load_done, err, word_count, fetch_q, mem_addr} !==
            {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, NOP, 7'd0}) begin
            errors++;
            $display("FAIL mf_reset: got %h, expected %h",
                     {mem_we, cpu_hold, host_ready, load_done, err, word_count, fetch_q, mem_addr},
                     {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, NOP, 7'd0});
        end
        tick();
        checks++;
        if (mem[40] !== 32'ha0000028) begin
            errors++;
            $display("FAIL mf_no_write: got mem[40]=%h, expected a0000028", mem[40]);
        end
        reset = 1'b1;
        #1;
        run_clear("reclear");
        checks++;
        if (mem[40] !== HALT) begin
            errors++;
            $display("FAIL mf_erased: got mem[40]=%h, expected %h", mem[40], HALT);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clear();
        test_load16();
        test_backpressure();
        test_overflow();
        test_restart();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
